// File: rtl/ka_pkg.sv
// Shared definitions for the Karatsuba operand splitter and its recombine counterpart:
// beat-select encodings (steer beats 0/1/2 to recombiner in1/in2/in3) and splitter FSM states.
package ka_pkg;

    localparam logic [1:0] KA_SEL_LO  = 2'd0;
    localparam logic [1:0] KA_SEL_MID = 2'd1;
    localparam logic [1:0] KA_SEL_HI  = 2'd2;

    typedef enum logic [1:0] {
        KA_ST_IDLE = 2'd0,
        KA_ST_LO   = 2'd1,
        KA_ST_MID  = 2'd2,
        KA_ST_HI   = 2'd3
    } ka_split_state_t;

endpackage

// File: rtl/ka_operand_split_12bit_if.sv
// Operand-in / sub-operand-out handshake bundle for ka_operand_split_12bit.
// Carries out_id only when KA_SPLIT_ID_EN is defined.
interface ka_operand_split_12bit_if #(
    parameter int N = 12
);
    localparam int H = N / 2;

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [H-1:0] out_a;
    logic [H-1:0] out_b;
    logic [1:0]   out_sel;
    logic         out_last;
`ifdef KA_SPLIT_ID_EN
    logic [1:0]   out_id;
`endif

    // Splitter side
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
`ifdef KA_SPLIT_ID_EN
        output out_id,
`endif
        output in_ready, out_valid, out_a, out_b, out_sel, out_last
    );

    // Upstream source / downstream sub-multiplier side
    modport master (
        output in_valid, in_a, in_b, out_ready,
`ifdef KA_SPLIT_ID_EN
        input  out_id,
`endif
        input  in_ready, out_valid, out_a, out_b, out_sel, out_last
    );

endinterface

// File: rtl/ka_operand_split_12bit.sv
// Karatsuba GF(2) operand splitter: one N-bit pair in, three H-bit sub-operand beats out (lo, lo^hi, hi).
// Optional KA_SPLIT_ID_EN adds a 2-bit per-pair transaction id on out_id.
//
// state      | meaning
// KA_ST_IDLE | no pair held, ready for a new one
// KA_ST_LO   | presenting low beat (a_lo, b_lo)
// KA_ST_MID  | presenting middle beat (a_lo^a_hi, b_lo^b_hi)
// KA_ST_HI   | presenting high beat; may accept the next pair on the same handshake
module ka_operand_split_12bit #(
    parameter int N = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    ka_operand_split_12bit_if.slave   bus
);
    import ka_pkg::*;

    localparam int H = N / 2;

    ka_split_state_t state_q, state_d;

    logic [H-1:0] a_lo_q, a_lo_d, a_hi_q, a_hi_d;
    logic [H-1:0] b_lo_q, b_lo_d, b_hi_q, b_hi_d;

    logic [H-1:0] out_a_q, out_a_d;
    logic [H-1:0] out_b_q, out_b_d;
    logic [1:0]   out_sel_q, out_sel_d;
    logic         out_last_q, out_last_d;

    logic out_valid;
    logic in_ready;
    logic fire;
    logic accept;

    assign out_valid = (state_q != KA_ST_IDLE);
    // in_ready must not depend on in_valid to keep the upstream handshake loop-free
    assign in_ready  = (state_q == KA_ST_IDLE) | ((state_q == KA_ST_HI) & bus.out_ready);
    assign fire      = out_valid & bus.out_ready;
    assign accept    = bus.in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        a_lo_d  = a_lo_q;
        a_hi_d  = a_hi_q;
        b_lo_d  = b_lo_q;
        b_hi_d  = b_hi_q;

        case (state_q)
            KA_ST_IDLE: if (accept) state_d = KA_ST_LO;
            KA_ST_LO:   if (fire)   state_d = KA_ST_MID;
            KA_ST_MID:  if (fire)   state_d = KA_ST_HI;
            KA_ST_HI: begin
                if (accept)     state_d = KA_ST_LO;
                else if (fire)  state_d = KA_ST_IDLE;
            end
            default:            state_d = KA_ST_IDLE;
        endcase

        if (accept) begin
            a_lo_d = bus.in_a[H-1:0];
            a_hi_d = bus.in_a[N-1:H];
            b_lo_d = bus.in_b[H-1:0];
            b_hi_d = bus.in_b[N-1:H];
        end
    end

    // Beat registers decode the upcoming state, so they hold naturally under backpressure
    always_comb begin
        out_a_d    = '0;
        out_b_d    = '0;
        out_sel_d  = KA_SEL_LO;
        out_last_d = 1'b0;

        case (state_d)
            KA_ST_LO: begin
                out_a_d   = a_lo_d;
                out_b_d   = b_lo_d;
                out_sel_d = KA_SEL_LO;
            end
            KA_ST_MID: begin
                out_a_d   = a_lo_d ^ a_hi_d;
                out_b_d   = b_lo_d ^ b_hi_d;
                out_sel_d = KA_SEL_MID;
            end
            KA_ST_HI: begin
                out_a_d    = a_hi_d;
                out_b_d    = b_hi_d;
                out_sel_d  = KA_SEL_HI;
                out_last_d = 1'b1;
            end
            default: begin
                out_a_d    = '0;
                out_b_d    = '0;
                out_sel_d  = KA_SEL_LO;
                out_last_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= KA_ST_IDLE;
            a_lo_q     <= '0;
            a_hi_q     <= '0;
            b_lo_q     <= '0;
            b_hi_q     <= '0;
            out_a_q    <= '0;
            out_b_q    <= '0;
            out_sel_q  <= KA_SEL_LO;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_lo_q     <= a_lo_d;
            a_hi_q     <= a_hi_d;
            b_lo_q     <= b_lo_d;
            b_hi_q     <= b_hi_d;
            out_a_q    <= out_a_d;
            out_b_q    <= out_b_d;
            out_sel_q  <= out_sel_d;
            out_last_q <= out_last_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_last  = out_last_q;

`ifdef KA_SPLIT_ID_EN
    logic [1:0] id_q, id_d;
    logic [1:0] out_id_q, out_id_d;

    // id_q is the id the next accepted pair will carry; out_id_q latches it for all three beats
    always_comb begin
        id_d     = id_q;
        out_id_d = out_id_q;
        if (accept) begin
            id_d     = id_q + 2'd1;
            out_id_d = id_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q     <= 2'd0;
            out_id_q <= 2'd0;
        end else begin
            id_q     <= id_d;
            out_id_q <= out_id_d;
        end
    end

    assign bus.out_id = out_id_q;
`endif

endmodule

// File: tb/tb_ka_operand_split_12bit.sv
// Self-checking bench for ka_operand_split_12bit: directed beat vectors plus a randomized
// run checked against a queue-of-beats reference model.
module tb_ka_operand_split_12bit;

    localparam int N = 12;
    localparam int H = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ka_operand_split_12bit_if #(.N(N)) bus ();

    ka_operand_split_12bit #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [H-1:0] a;
        logic [H-1:0] b;
        logic [1:0]   sel;
        logic         last;
        logic [1:0]   id;
    } beat_t;

    beat_t exp_q[$];
    int    acc_cnt;

    // Reference: split by plain integer arithmetic, middle term is XOR of halves
    function automatic void push_pair(input logic [N-1:0] a, input logic [N-1:0] b);
        int    alo, ahi, blo, bhi;
        beat_t bt;
        alo = int'(a) % 64;  ahi = int'(a) / 64;
        blo = int'(b) % 64;  bhi = int'(b) / 64;
        bt.id = 2'(acc_cnt % 4);
        bt.a = 6'(alo);        bt.b = 6'(blo);        bt.sel = 2'd0; bt.last = 1'b0; exp_q.push_back(bt);
        bt.a = 6'(alo ^ ahi);  bt.b = 6'(blo ^ bhi);  bt.sel = 2'd1; bt.last = 1'b0; exp_q.push_back(bt);
        bt.a = 6'(ahi);        bt.b = 6'(bhi);        bt.sel = 2'd2; bt.last = 1'b1; exp_q.push_back(bt);
        acc_cnt++;
    endfunction

    function automatic logic model_ready();
        return (exp_q.size() == 0) || (exp_q.size() == 1 && bus.out_ready);
    endfunction

    // Apply the handshakes the currently driven inputs will cause at the next rising edge
    function automatic void model_advance();
        logic acc;
        acc = bus.in_valid && model_ready();
        if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
        if (acc) push_pair(bus.in_a, bus.in_b);
    endfunction

    task automatic drive(input logic v, input logic [N-1:0] a, input logic [N-1:0] b, input logic rdy);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.out_ready = rdy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        acc_cnt = 0;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b1;
        bus.in_a      = 12'hABC;
        bus.in_b      = 12'h123;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.out_a !== 6'h00)    begin bad++; $display("FAIL reset_out_a got=%h want=00", bus.out_a); end
        total++; if (bus.out_b !== 6'h00)    begin bad++; $display("FAIL reset_out_b got=%h want=00", bus.out_b); end
        total++; if (bus.out_sel !== 2'd0)   begin bad++; $display("FAIL reset_out_sel got=%0d want=0", bus.out_sel); end
        total++; if (bus.out_last !== 1'b0)  begin bad++; $display("FAIL reset_out_last got=%b want=0", bus.out_last); end
        total++; if (bus.in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
`ifdef KA_SPLIT_ID_EN
        total++; if (bus.out_id !== 2'd0)    begin bad++; $display("FAIL reset_out_id got=%0d want=0", bus.out_id); end
`endif
        do_reset();
    endtask

    task automatic test_basic();
        logic [H-1:0] ea[3];
        logic [H-1:0] eb[3];
        ea = '{6'h1C, 6'h35, 6'h29};
        eb = '{6'h31, 6'h3E, 6'h0F};
        drive(1'b1, 12'hA5C, 12'h3F1, 1'b1);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL basic_accept_ready got=%b want=1", bus.in_ready); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, '0, 1'b1);
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid beat%0d got=%b want=1", i, bus.out_valid); end
            total++; if (bus.out_a !== ea[i])    begin bad++; $display("FAIL basic_a beat%0d got=%h want=%h", i, bus.out_a, ea[i]); end
            total++; if (bus.out_b !== eb[i])    begin bad++; $display("FAIL basic_b beat%0d got=%h want=%h", i, bus.out_b, eb[i]); end
            total++; if (bus.out_sel !== 2'(i))  begin bad++; $display("FAIL basic_sel beat%0d got=%0d want=%0d", i, bus.out_sel, i); end
            total++; if (bus.out_last !== (i == 2)) begin bad++; $display("FAIL basic_last beat%0d got=%b want=%b", i, bus.out_last, i == 2); end
        end
        drive(1'b0, '0, '0, 1'b1);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_idle_valid got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 12'hA5C, 12'h3F1, 1'b1);
        drive(1'b0, '0, '0, 1'b1);
        total++; if (bus.out_sel !== 2'd0) begin bad++; $display("FAIL bp_lo_sel got=%0d want=0", bus.out_sel); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 12'h777, 12'h555, 1'b0);
            total++; if (bus.out_a !== 6'h35 || bus.out_b !== 6'h3E || bus.out_sel !== 2'd1 || bus.out_valid !== 1'b1)
                begin bad++; $display("FAIL bp_hold cyc%0d got=%h/%h/%0d/%b want=35/3e/1/1", i, bus.out_a, bus.out_b, bus.out_sel, bus.out_valid); end
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc%0d got=%b want=0", i, bus.in_ready); end
        end
        drive(1'b0, '0, '0, 1'b1);
        total++; if (bus.out_sel !== 2'd1 || bus.out_a !== 6'h35) begin bad++; $display("FAIL bp_mid_release got=%h/%0d want=35/1", bus.out_a, bus.out_sel); end
        drive(1'b0, '0, '0, 1'b1);
        total++; if (bus.out_a !== 6'h29 || bus.out_b !== 6'h0F || bus.out_sel !== 2'd2 || bus.out_last !== 1'b1)
            begin bad++; $display("FAIL bp_hi got=%h/%h/%0d/%b want=29/0f/2/1", bus.out_a, bus.out_b, bus.out_sel, bus.out_last); end
        drive(1'b0, '0, '0, 1'b1);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_idle got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_allones();
        logic [H-1:0] ea[3];
        ea = '{6'h3F, 6'h00, 6'h3F};
        drive(1'b1, 12'hFFF, 12'h000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, '0, 1'b1);
            total++; if (bus.out_a !== ea[i] || bus.out_b !== 6'h00 || bus.out_valid !== 1'b1)
                begin bad++; $display("FAIL allones beat%0d got=%h/%h/%b want=%h/00/1", i, bus.out_a, bus.out_b, bus.out_valid, ea[i]); end
        end
        drive(1'b0, '0, '0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] pa[2];
        logic [N-1:0] pb[2];
        int sent, beats, first_c, last_c;
        do_reset();
        for (int i = 0; i < 2; i++) begin pa[i] = N'($urandom); pb[i] = N'($urandom); end
        sent = 0; beats = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 9; c++) begin
            if (sent < 2) drive(1'b1, pa[sent], pb[sent], 1'b1);
            else          drive(1'b0, '0, '0, 1'b1);
            total++; if (bus.out_valid !== (exp_q.size() != 0)) begin bad++; $display("FAIL b2b_valid cyc%0d got=%b want=%b", c, bus.out_valid, exp_q.size() != 0); end
            total++; if (bus.in_ready !== model_ready()) begin bad++; $display("FAIL b2b_in_ready cyc%0d got=%b want=%b", c, bus.in_ready, model_ready()); end
            if (exp_q.size() != 0) begin
                total++; if (bus.out_a !== exp_q[0].a || bus.out_b !== exp_q[0].b || bus.out_sel !== exp_q[0].sel)
                    begin bad++; $display("FAIL b2b_beat cyc%0d got=%h/%h/%0d want=%h/%h/%0d", c, bus.out_a, bus.out_b, bus.out_sel, exp_q[0].a, exp_q[0].b, exp_q[0].sel); end
            end
            if (bus.out_valid === 1'b1) begin
                beats++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            if (bus.in_valid && model_ready()) sent++;
            model_advance();
        end
        total++; if (beats != 6 || first_c != 1 || last_c != 6)
            begin bad++; $display("FAIL b2b_count got=%0d beats cyc%0d..%0d want=6 beats cyc1..6", beats, first_c, last_c); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 12'hA5C, 12'h3F1, 1'b1);
        drive(1'b0, '0, '0, 1'b1);
        drive(1'b0, '0, '0, 1'b1);
        total++; if (bus.out_sel !== 2'd1 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%0d/%b want=1/1", bus.out_sel, bus.out_valid); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_async_valid got=%b want=0", bus.out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        acc_cnt = 0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%b want=1", bus.in_ready); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, '0, 1'b1);
            total++; if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0)
                begin bad++; $display("FAIL rstmid_no_hi cyc%0d got=%b/%b want=0/0", i, bus.out_valid, bus.out_last); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 1)), N'($urandom), N'($urandom), ($urandom_range(0, 3) != 0));
            total++; if (bus.out_valid !== (exp_q.size() != 0)) begin bad++; $display("FAIL rnd_valid cyc%0d got=%b want=%b", c, bus.out_valid, exp_q.size() != 0); end
            total++; if (bus.in_ready !== model_ready()) begin bad++; $display("FAIL rnd_in_ready cyc%0d got=%b want=%b", c, bus.in_ready, model_ready()); end
            if (exp_q.size() != 0) begin
                total++; if (bus.out_a !== exp_q[0].a || bus.out_b !== exp_q[0].b || bus.out_sel !== exp_q[0].sel || bus.out_last !== exp_q[0].last)
                    begin bad++; $display("FAIL rnd_beat cyc%0d got=%h/%h/%0d/%b want=%h/%h/%0d/%b", c, bus.out_a, bus.out_b, bus.out_sel, bus.out_last,
                                          exp_q[0].a, exp_q[0].b, exp_q[0].sel, exp_q[0].last); end
`ifdef KA_SPLIT_ID_EN
                total++; if (bus.out_id !== exp_q[0].id) begin bad++; $display("FAIL rnd_id cyc%0d got=%0d want=%0d", c, bus.out_id, exp_q[0].id); end
`endif
            end
            model_advance();
        end
    endtask

`ifdef KA_SPLIT_ID_EN
    task automatic test_id();
        int k;
        do_reset();
        k = 0;
        for (int c = 0; c < 20 && k < 15; c++) begin
            drive((c < 13), N'($urandom), N'($urandom), 1'b1);
            if (bus.out_valid === 1'b1) begin
                total++; if (bus.out_id !== 2'((k / 3) % 4)) begin bad++; $display("FAIL id_seq beat%0d got=%0d want=%0d", k, bus.out_id, (k / 3) % 4); end
                k++;
            end
        end
        total++; if (k != 15) begin bad++; $display("FAIL id_beats got=%0d want=15", k); end
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        acc_cnt       = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_allones();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef KA_SPLIT_ID_EN
        test_id();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
